dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the memory pipeline stage.
- Accepts the stage's combinational dddr_* request, holds the pipeline with a stall while a fixed number of wait states elapse, then returns a one-cycle dddr_resp with read data.
- Backs a word-addressed on-chip RAM.
- Sits between the memory stage and the pipeline stall network.

---
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: holds the pipeline for LATENCY wait states, then returns a one-cycle response.
// Optional `DMEM_PERF_EN adds read/write/stall performance counters.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dddr_addr,
  input  logic        dddr_read,
  input  logic        dddr_write,
  input  logic [31:0] dddr_wdata,
  output logic [31:0] dddr_rdata,
  output logic        dddr_resp,
  output logic        dddr_err,
  output logic        mem_stall
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_reads,
  output logic [31:0] perf_writes,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        resp_q, resp_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req, in_idle, go_resp, op_rd, op_wr, op_err, mem_we;
  logic [29:0] op_idx;
  logic [31:0] op_wdata;
  logic [AW-1:0] mem_idx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^dddr_addr[1:0];
  assign req       = dddr_read | dddr_write;
  assign mem_stall = req & ~resp_q;

  // With LATENCY=0 the access completes on the capture edge, so operands come straight from the ports.
  always_comb begin
    in_idle  = (state_q == S_IDLE);
    op_idx   = in_idle ? dddr_addr[31:2] : idx_q;
    op_wdata = in_idle ? dddr_wdata      : wdata_q;
    op_rd    = in_idle ? dddr_read       : rd_q;
    op_wr    = in_idle ? dddr_write      : wr_q;
    op_err   = (op_rd & op_wr) | ({2'b00, op_idx} >= 32'(DEPTH_WORDS));
    go_resp  = req & ((in_idle & (LAT == 4'd0)) | ((state_q == S_WAIT) & (cnt_q == 4'd1)));
    mem_idx  = op_idx[AW-1:0];
    mem_we   = go_resp & op_wr & ~op_err & rst_n;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = dddr_addr[31:2];
          wdata_d = dddr_wdata;
          rd_d    = dddr_read;
          wr_d    = dddr_write;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      resp_d = 1'b1;
      err_d  = op_err;
      if (op_rd && !op_err) rdata_d = mem[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 30'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= op_wdata;
  end

  assign dddr_resp  = resp_q;
  assign dddr_err   = err_q;
  assign dddr_rdata = rdata_q;

`ifdef DMEM_PERF_EN
  logic [31:0] perf_reads_q, perf_reads_d;
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_reads_d  = perf_reads_q  + {31'd0, go_resp & op_rd & ~op_err};
    perf_writes_d = perf_writes_q + {31'd0, go_resp & op_wr & ~op_err};
    perf_stall_d  = perf_stall_q  + {31'd0, mem_stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reads_q  <= 32'd0;
      perf_writes_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_reads        = perf_reads_q;
  assign perf_writes       = perf_writes_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl: three instances (LATENCY 0/2/4) checked against a word-array model.
module tb_dmem_ctrl;

  localparam int NU = 3;
  localparam int LATS   [NU] = '{0, 2, 4};
  localparam int DEPTHS [NU] = '{16, 1024, 1024};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  [NU];
  logic [31:0] wdata [NU];
  logic        rd    [NU];
  logic        wr    [NU];
  logic [31:0] rdata [NU];
  logic        resp  [NU];
  logic        err   [NU];
  logic        stall [NU];
  logic [31:0] p_rd  [NU];
  logic [31:0] p_wr  [NU];
  logic [31:0] p_st  [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    dmem_ctrl #(.DEPTH_WORDS(DEPTHS[g]), .LATENCY(LATS[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dddr_addr  (addr[g]),
      .dddr_read  (rd[g]),
      .dddr_write (wr[g]),
      .dddr_wdata (wdata[g]),
      .dddr_rdata (rdata[g]),
      .dddr_resp  (resp[g]),
      .dddr_err   (err[g]),
      .mem_stall  (stall[g])
`ifdef DMEM_PERF_EN
      ,
      .perf_reads        (p_rd[g]),
      .perf_writes       (p_wr[g]),
      .perf_stall_cycles (p_st[g])
`endif
    );
`ifndef DMEM_PERF_EN
    assign p_rd[g] = 32'd0;
    assign p_wr[g] = 32'd0;
    assign p_st[g] = 32'd0;
`endif
  end

  // reference model: word array, last returned read data, expected perf counts
  logic [31:0] mdl [NU][1024];
  logic [31:0] mdl_rdata [NU];
  int exp_reads [NU];
  int exp_writes[NU];
  int exp_stall [NU];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drives one request (left asserted on return, sitting in the resp cycle) and checks it.
  task automatic access(input int u, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit b2b);
    int n, n_exp, idx;
    bit got, stall_ok, err_e;
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    #1;
    check_val($sformatf("stall_start u%0d", u), {31'd0, stall[u]}, b2b ? 32'd0 : 32'd1);
    n_exp = LATS[u] + 1 + (b2b ? 1 : 0);
    n = 0; got = 0; stall_ok = 1;
    while (n < 30 && !got) begin
      @(posedge clk); #1;
      n++;
      got = resp[u];
      if (!got) begin
        if (!stall[u]) stall_ok = 0;
        if (n >= (b2b ? 2 : 1)) begin
          addr[u]  = $urandom;
          wdata[u] = $urandom;
        end
      end
    end
    check_val($sformatf("latency u%0d", u), n, n_exp);
    check_val($sformatf("stall_wait u%0d", u), {31'd0, stall_ok}, 32'd1);
    check_val($sformatf("stall_resp u%0d", u), {31'd0, stall[u]}, 32'd0);
    idx   = int'(a[31:2]);
    err_e = (r && w) || (idx >= DEPTHS[u]);
    if (r && !err_e) begin
      mdl_rdata[u] = mdl[u][idx];
      exp_reads[u]++;
    end
    if (w && !err_e) begin
      mdl[u][idx] = d;
      exp_writes[u]++;
    end
    exp_stall[u] += LATS[u] + 1;
    check_val($sformatf("err u%0d a=%h", u, a), {31'd0, err[u]}, {31'd0, err_e});
    check_val($sformatf("rdata u%0d a=%h", u, a), rdata[u], mdl_rdata[u]);
  endtask

  task automatic drop(input int u);
    rd[u] = 0; wr[u] = 0;
    @(posedge clk); #1;
    check_val($sformatf("resp_pulse u%0d", u), {31'd0, resp[u]}, 32'd0);
  endtask

  // Request held for k capture/wait edges, then withdrawn: no response, no write.
  task automatic flush(input int u, input bit w, input logic [31:0] a, input logic [31:0] d, input int k);
    bit seen;
    seen = 0;
    rd[u] = !w; wr[u] = w; addr[u] = a; wdata[u] = d;
    repeat (k) begin
      @(posedge clk); #1;
      if (resp[u]) seen = 1;
    end
    rd[u] = 0; wr[u] = 0;
    repeat (LATS[u] + 3) begin
      @(posedge clk); #1;
      if (resp[u]) seen = 1;
    end
    exp_stall[u] += k;
    check_val($sformatf("flush_noresp u%0d", u), {31'd0, seen}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag, input int u);
    check_val({tag, "_resp"},  {31'd0, resp[u]},  32'd0);
    check_val({tag, "_err"},   {31'd0, err[u]},   32'd0);
    check_val({tag, "_rdata"}, rdata[u],          32'd0);
    check_val({tag, "_stall"}, {31'd0, stall[u]}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr(input int u, input bit oob);
    logic [31:0] a;
    a = {$urandom} & 32'h3;
    if (!oob)                   a[31:2] = 30'($urandom_range(0, 15));
    else if ($urandom_range(0, 1) == 0) a[31:2] = 30'(DEPTHS[u] + $urandom_range(0, 3));
    else                        a[31:2] = 30'h2000_0000 | 30'($urandom);
    return a;
  endfunction

  initial begin
    int u, op, k;
    logic [31:0] a;
    for (int i = 0; i < NU; i++) begin
      addr[i] = 0; wdata[i] = 0; rd[i] = 0; wr[i] = 0;
      mdl_rdata[i] = 0; exp_reads[i] = 0; exp_writes[i] = 0; exp_stall[i] = 0;
      for (int j = 0; j < 1024; j++) mdl[i][j] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) check_idle_outputs($sformatf("reset u%0d", i), i);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < NU; i++)
      for (int j = 0; j < 16; j++) begin
        access(i, 0, 1, 32'(j * 4), $urandom, 0);
        drop(i);
      end

    access(1, 0, 1, 32'h40, 32'hDEADBEEF, 0); drop(1);
    access(1, 1, 0, 32'h40, 32'h0, 0);
    check_val("plan_rd_40", rdata[1], 32'hDEADBEEF);
    drop(1);
    access(1, 0, 1, 32'h0, 32'h11, 0); drop(1);
    access(1, 0, 1, 32'h4, 32'h22, 0); drop(1);
    access(1, 1, 0, 32'h4, 32'h0, 0);  drop(1);
    access(1, 0, 1, 32'h1000, 32'hBAD0BAD0, 0); drop(1);
    access(1, 1, 0, 32'h1000, 32'h0, 0);
    check_val("plan_oob_hold", rdata[1], 32'h22);
    drop(1);
    access(1, 1, 1, 32'h8, 32'h12345678, 0); drop(1);
    access(1, 1, 0, 32'h8, 32'h0, 0); drop(1);

    access(0, 0, 1, 32'h0, 32'h11, 0); drop(0);
    access(0, 0, 1, 32'h4, 32'h22, 0); drop(0);
    access(0, 1, 0, 32'h0, 32'h0, 0);
    check_val("plan_b2b_0", rdata[0], 32'h11);
    access(0, 1, 0, 32'h4, 32'h0, 1);
    check_val("plan_b2b_4", rdata[0], 32'h22);
    drop(0);

    flush(2, 1, 32'hC, 32'h5, 2);
    access(2, 1, 0, 32'hC, 32'h0, 0); drop(2);

    // async reset during a pending write: outputs clear, RAM untouched
    rd[2] = 0; wr[2] = 1; addr[2] = 32'h10; wdata[2] = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0; wr[2] = 0;
    #1;
    for (int i = 0; i < NU; i++) begin
      check_idle_outputs($sformatf("midreset u%0d", i), i);
      mdl_rdata[i] = 0; exp_reads[i] = 0; exp_writes[i] = 0; exp_stall[i] = 0;
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    access(2, 1, 0, 32'h10, 32'h0, 0); drop(2);

    for (int it = 0; it < 150; it++) begin
      u  = $urandom_range(0, NU - 1);
      op = $urandom_range(0, 9);
      if (op == 9 && LATS[u] == 0) op = 0;
      case (op)
        0, 1, 2, 3: access(u, 1, 0, rand_addr(u, 0), $urandom, 0);
        4, 5, 6:    access(u, 0, 1, rand_addr(u, 0), $urandom, 0);
        7: begin
          if ($urandom_range(0, 1) == 0) access(u, 1, 0, rand_addr(u, 1), $urandom, 0);
          else                           access(u, 0, 1, rand_addr(u, 1), $urandom, 0);
        end
        8:       access(u, 1, 1, rand_addr(u, 0), $urandom, 0);
        default: begin
          k = $urandom_range(1, LATS[u]);
          a = rand_addr(u, 0);
          flush(u, $urandom_range(0, 1) == 1, a, $urandom, k);
          access(u, 1, 0, a, 32'h0, 0);
        end
      endcase
      if ($urandom_range(0, 2) == 0) access(u, 1, 0, rand_addr(u, 0), 32'h0, 1);
      drop(u);
    end

`ifdef DMEM_PERF_EN
    for (int i = 0; i < NU; i++) begin
      check_val($sformatf("perf_reads u%0d", i),  p_rd[i], 32'(exp_reads[i]));
      check_val($sformatf("perf_writes u%0d", i), p_wr[i], 32'(exp_writes[i]));
      check_val($sformatf("perf_stall u%0d", i),  p_st[i], 32'(exp_stall[i]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
